neural_mem_bank: RTL and testbench

Parametrised successor to the single 32x9 stage-memory wrapper: a multi-bank, low-order-interleaved 1R1W data memory for a network stage. It adds a configurable read latency, write-first bypass, an accumulate (read-modify-write add) write mode for partial-sum and weight-update storage, and a post-reset clearing sweep. It sits between a stage controller and the stage datapath.

---
 rtl/neural_mem_bank_if.sv | 25 ++
 rtl/neural_mem_bank.sv | 149 ++++++++++++++
 tb/tb_neural_mem_bank.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/neural_mem_bank_if.sv
// Command/response bus between a stage controller (master) and neural_mem_bank (slave).
interface neural_mem_bank_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 11
);
  logic             ready;
  logic             wr_en;
  logic             wr_mode;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  modport master (
    input  ready, rd_data, rd_valid,
    output wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/neural_mem_bank.sv
// Low-order-interleaved multi-bank 1R1W memory with accumulate writes, write-first
// bypass, configurable read latency and a post-reset clearing sweep.
module neural_mem_bank #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BANKS      = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  neural_mem_bank_if.slave  bus
);

  localparam int unsigned AW  = $clog2(BANKS * DEPTH);
  localparam int unsigned LBW = $clog2(BANKS);
  localparam int unsigned BW  = (LBW == 0) ? 1 : LBW;
  localparam int unsigned WW  = $clog2(DEPTH);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
    return BW'(a & AW'(BANKS - 1));
  endfunction

  function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
    return WW'(a >> LBW);
  endfunction

  logic [0:0]       state, state_next;
  logic [WW-1:0]    clr_cnt, cnt_next;
  logic             ready_q;

  logic             p_valid;
  logic [AW-1:0]    p_addr;
  logic [WIDTH-1:0] p_sum;

  logic             wr_acc, rd_acc, p_commit, ow_commit;
  logic [BW-1:0]    wr_bank, rd_bank, p_bank;
  logic [WW-1:0]    wr_word, rd_word, p_word;
  logic [WIDTH-1:0] bank_old [BANKS];
  logic [WIDTH-1:0] bank_rd  [BANKS];
  logic [WIDTH-1:0] old_val, acc_sum, rd_val;

  logic             s1_valid, rd_valid_q, src_valid;
  logic [WIDTH-1:0] s1_data, rd_data_q, src_data;

  // Commands are only taken in RUN and never in a cycle where reset is sampled.
  assign wr_acc    = ready_q & bus.wr_en & ~reset;
  assign rd_acc    = ready_q & bus.rd_en & ~reset;
  assign p_commit  = p_valid & ~reset;
  assign ow_commit = wr_acc & ~bus.wr_mode;

  assign wr_bank = bank_of(bus.wr_addr);
  assign wr_word = word_of(bus.wr_addr);
  assign rd_bank = bank_of(bus.rd_addr);
  assign rd_word = word_of(bus.rd_addr);
  assign p_bank  = bank_of(p_addr);
  assign p_word  = word_of(p_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= cnt_next;
      ready_q <= (state_next == S_RUN);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = clr_cnt;
    case (state)
      S_CLEAR: begin
        cnt_next = clr_cnt + WW'(1);
        if (clr_cnt == WW'(DEPTH - 1)) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  // Pending accumulate commits before a same-cycle overwrite, so the later overwrite wins.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (p_commit && p_bank == BW'(b)) mem[p_word] <= p_sum;
        if (ow_commit && wr_bank == BW'(b)) mem[wr_word] <= bus.wr_data;
      end
    end

    assign bank_old[b] = mem[wr_word];
    assign bank_rd[b]  = mem[rd_word];
  end

  // Write-first view: stage P sum overrides memory, a same-cycle write overrides both.
  always_comb begin
    old_val = (p_valid && p_addr == bus.wr_addr) ? p_sum : bank_old[wr_bank];
    acc_sum = old_val + bus.wr_data;
    rd_val  = (p_valid && p_addr == bus.rd_addr) ? p_sum : bank_rd[rd_bank];
    if (wr_acc && bus.wr_addr == bus.rd_addr) begin
      rd_val = bus.wr_mode ? acc_sum : bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_sum   <= '0;
    end else begin
      p_valid <= wr_acc & bus.wr_mode;
      p_addr  <= bus.wr_addr;
      p_sum   <= acc_sum;
    end
  end

  assign src_valid = (RD_LATENCY == 1) ? rd_acc : s1_valid;
  assign src_data  = (RD_LATENCY == 1) ? rd_val : s1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid   <= rd_acc;
      s1_data    <= rd_val;
      rd_valid_q <= src_valid;
      if (src_valid) rd_data_q <= src_data;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_neural_mem_bank.sv
// Directed + random bench for neural_mem_bank, latency 1 and 2 instances driven in lockstep
// against a command-ordered array model.
module tb_neural_mem_bank;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned BANKS = 4;
  localparam int unsigned AW    = 11;
  localparam int unsigned NW    = BANKS * DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  neural_mem_bank_if #(.WIDTH(W), .AW(AW)) bus1 ();
  neural_mem_bank_if #(.WIDTH(W), .AW(AW)) bus2 ();

  neural_mem_bank #(.WIDTH(W), .DEPTH(DEPTH), .BANKS(BANKS), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));
  neural_mem_bank #(.WIDTH(W), .DEPTH(DEPTH), .BANKS(BANKS), .RD_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .bus(bus2));

  logic [W-1:0] mdl [NW];
  int unsigned  since;
  bit           exp_ready;
  bit           e1_v, e2_s1v, e2_v;
  logic [W-1:0] e1_d, e2_s1d, e2_d;
  int           checks = 0;
  int           passes = 0;
  int           fails  = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive both DUTs, apply accepted commands to the model in order, then check.
  task automatic step(input bit rst, input bit we, input bit wm, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input bit re, input logic [AW-1:0] ra);
    bit acc, rv;
    logic [W-1:0] rdv;
    reset = rst;
    bus1.wr_en = we; bus1.wr_mode = wm; bus1.wr_addr = wa; bus1.wr_data = wd;
    bus1.rd_en = re; bus1.rd_addr = ra;
    bus2.wr_en = we; bus2.wr_mode = wm; bus2.wr_addr = wa; bus2.wr_data = wd;
    bus2.rd_en = re; bus2.rd_addr = ra;
    acc = !rst && exp_ready;
    rv  = 1'b0;
    rdv = '0;
    if (acc && we) mdl[wa] = wm ? mdl[wa] + wd : wd;
    if (acc && re) begin
      rv  = 1'b1;
      rdv = mdl[ra];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      since = 0; exp_ready = 1'b0;
      e1_v = 1'b0; e1_d = '0;
      e2_s1v = 1'b0; e2_s1d = '0; e2_v = 1'b0; e2_d = '0;
      for (int i = 0; i < NW; i++) mdl[i] = '0;
    end else begin
      since++;
      exp_ready = (since >= DEPTH);
      e1_v = rv;
      if (rv) e1_d = rdv;
      e2_v = e2_s1v;
      if (e2_s1v) e2_d = e2_s1d;
      e2_s1v = rv;
      e2_s1d = rdv;
    end
    chk("ready_l1",    W'(bus1.ready),    W'(exp_ready));
    chk("ready_l2",    W'(bus2.ready),    W'(exp_ready));
    chk("rd_valid_l1", W'(bus1.rd_valid), W'(e1_v));
    chk("rd_valid_l2", W'(bus2.rd_valid), W'(e2_v));
    chk("rd_data_l1",  bus1.rd_data,      e1_d);
    chk("rd_data_l2",  bus2.rd_data,      e2_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic sweep_and_count();
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      n++;
    end while (!bus1.ready && n < 2 * DEPTH);
    chk("ready_rise_cycles", W'(n), W'(DEPTH));
  endtask

  initial begin
    logic [AW-1:0] wa, ra;
    since = 0; exp_ready = 1'b0;
    e1_v = 1'b0; e1_d = '0; e2_s1v = 1'b0; e2_s1d = '0; e2_v = 1'b0; e2_d = '0;
    for (int i = 0; i < NW; i++) mdl[i] = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    sweep_and_count();

    // Post-sweep reads, spaced so each latency is seen in isolation.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd0);    idle(3);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd5);    idle(3);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd2047); idle(3);

    // Same-cycle overwrite bypass, then a neighbouring word.
    step(1'b0, 1'b1, 1'b0, 11'd6, 32'hDEADBEEF, 1'b1, 11'd6);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd7);
    idle(3);

    // Chained accumulates and wraparound.
    step(1'b0, 1'b1, 1'b1, 11'd10, 32'd1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 11'd10, 32'd2, 1'b1, 11'd10);
    step(1'b0, 1'b1, 1'b1, 11'd10, 32'd3, 1'b1, 11'd10);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd10);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 11'd20, 32'hFFFFFFFF, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 11'd20, 32'd1, 1'b1, 11'd20);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd20);
    idle(3);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd20);
    idle(3);

    // Accumulate/overwrite ordering in both directions.
    step(1'b0, 1'b1, 1'b1, 11'd3, 32'd5, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 11'd3, 32'd9, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd3);
    idle(2);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd3);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 11'd30, 32'd9, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 11'd30, 32'd5, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd30);
    idle(3);

    // Streaming reads across all banks with concurrent writes to a different bank.
    for (int i = 0; i < 64; i++) begin
      ra = AW'(i);
      wa = AW'(((i + 2) % BANKS) + (($urandom % DEPTH) * BANKS));
      step(1'b0, 1'b1, 1'($urandom % 2), wa, $urandom, 1'b1, ra);
    end
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
    idle(3);

    // Random traffic over a small window to force address collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom % 2), 1'($urandom % 2), AW'($urandom % 16), $urandom,
           1'($urandom % 2), AW'($urandom % 16));
    end
    idle(3);

    // Reset in the middle of a read burst with an accumulate in flight.
    step(1'b0, 1'b1, 1'b1, 11'd12, 32'd77, 1'b1, 11'd12);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 11'd13);
    step(1'b1, 1'b1, 1'b1, 11'd12, 32'd1, 1'b1, 11'd12);
    idle(100);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    sweep_and_count();
    for (int i = 0; i < NW; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
